// File: rtl/obf_state_bank.sv
`default_nettype none
// ============================================================================
//  Module      : obf_state_bank
//  Description : WIDTH-bit restorable state register with a DEPTH-entry
//                circular checkpoint buffer. On request it substitutes a
//                past next-state value into q, then swaps the live value back.
//  Revision    : 1.0 - initial release
// ============================================================================
module obf_state_bank #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int SEL_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    input  logic             capture_en,
    input  logic             freeze,
    input  logic             restore_req,
    input  logic [SEL_W-1:0] restore_sel,
    output logic             busy,
    output logic [SEL_W:0]   ckpt_count,
    output logic             restore_done,
    output logic             restore_err
);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_FREEZE    = 2'd1,
        ST_RESTORE   = 2'd2,
        ST_SWAP_BACK = 2'd3
    } state_t;

    localparam logic [SEL_W:0] c_depth = (SEL_W + 1)'(DEPTH);

    state_t           r_state;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_hold;
    logic [WIDTH-1:0] r_buf [DEPTH];
    logic [SEL_W-1:0] r_wr_ptr;
    logic [SEL_W:0]   r_count;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    logic [SEL_W-1:0] w_rd_idx;
    logic             w_sel_valid;

    // Age 0 is the entry just behind the write pointer; SEL_W-bit arithmetic wraps modulo DEPTH.
    always_comb begin
        w_rd_idx    = r_wr_ptr - SEL_W'(1) - restore_sel;
        w_sel_valid = ({1'b0, restore_sel} < r_count);
    end

    // Bank state machine: state, live register, hold register and checkpoint ring.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= ST_RUN;
            r_q      <= '0;
            r_hold   <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    r_q <= d;
                    if (freeze) begin
                        r_state <= ST_FREEZE;
                    end else if (restore_req && w_sel_valid) begin
                        // The live value is parked so it can be swapped back afterwards.
                        r_hold  <= r_q;
                        r_q     <= r_buf[w_rd_idx];
                        r_state <= ST_RESTORE;
                        r_busy  <= 1'b1;
                    end else begin
                        if (restore_req) begin
                            r_err <= 1'b1;
                        end
                        if (capture_en) begin
                            r_buf[r_wr_ptr] <= d;
                            r_wr_ptr        <= r_wr_ptr + SEL_W'(1);
                            if (r_count != c_depth) begin
                                r_count <= r_count + (SEL_W + 1)'(1);
                            end
                        end
                    end
                end
                ST_FREEZE: begin
                    r_q <= d;
                    if (!freeze) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RESTORE: begin
                    // q keeps the checkpoint until the request is withdrawn.
                    if (!restore_req) begin
                        r_q     <= r_hold;
                        r_done  <= 1'b1;
                        r_state <= ST_SWAP_BACK;
                    end
                end
                ST_SWAP_BACK: begin
                    r_q     <= d;
                    r_busy  <= 1'b0;
                    r_state <= ST_RUN;
                end
                default: begin
                    r_state <= ST_RUN;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign q            = r_q;
    assign busy         = r_busy;
    assign ckpt_count   = r_count;
    assign restore_done = r_done;
    assign restore_err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_obf_state_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_obf_state_bank
//  Description : Directed self-checking bench for obf_state_bank.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_obf_state_bank;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int SEL_W = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             capture_en;
    logic             freeze;
    logic             restore_req;
    logic [SEL_W-1:0] restore_sel;
    logic             busy;
    logic [SEL_W:0]   ckpt_count;
    logic             restore_done;
    logic             restore_err;

    int n_checks = 0;
    int n_errors = 0;

    obf_state_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SEL_W(SEL_W)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .d            (d),
        .q            (q),
        .capture_en   (capture_en),
        .freeze       (freeze),
        .restore_req  (restore_req),
        .restore_sel  (restore_sel),
        .busy         (busy),
        .ckpt_count   (ckpt_count),
        .restore_done (restore_done),
        .restore_err  (restore_err)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one clock edge; outputs settle 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic [7:0] v);
        capture_en = 1'b1;
        d          = v;
        step();
        capture_en = 1'b0;
    endtask

    initial begin
        reset = 1'b0; d = 8'hFF; capture_en = 1'b1;
        freeze = 1'b0; restore_req = 1'b0; restore_sel = '0;

        // Reset held for two cycles against capture and d activity
        step(); step();
        check_eq("rst_q", 32'(q), 32'h00);
        check_eq("rst_count", 32'(ckpt_count), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(restore_done), 0);
        check_eq("rst_err", 32'(restore_err), 0);

        // Capture three values then restore age 1
        reset = 1'b1;
        capture(8'h11); capture(8'h22); capture(8'h33);
        check_eq("cap_count", 32'(ckpt_count), 3);
        check_eq("cap_q", 32'(q), 32'h33);
        d = 8'h44; step();
        check_eq("run_q44", 32'(q), 32'h44);
        restore_req = 1'b1; restore_sel = 2'd1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("rs_q", 32'(q), 32'h22);
            check_eq("rs_busy", 32'(busy), 1);
        end
        restore_req = 1'b0;
        step();
        check_eq("swap_q", 32'(q), 32'h44);
        check_eq("swap_done", 32'(restore_done), 1);
        check_eq("swap_busy", 32'(busy), 1);
        d = 8'h55; step();
        check_eq("post_q", 32'(q), 32'h55);
        check_eq("post_done", 32'(restore_done), 0);
        check_eq("post_busy", 32'(busy), 0);
        check_eq("post_count", 32'(ckpt_count), 3);

        // Wrap and overwrite with six captures
        reset = 1'b0; step(); reset = 1'b1;
        for (int i = 1; i <= 6; i++) capture(8'(i));
        check_eq("wrap_count", 32'(ckpt_count), 4);
        d = 8'hAA; restore_req = 1'b1; restore_sel = 2'd0; step();
        check_eq("wrap_sel0", 32'(q), 32'h06);
        restore_req = 1'b0; step(); step();
        check_eq("wrap_run", 32'(q), 32'hAA);
        restore_req = 1'b1; restore_sel = 2'd3; step();
        check_eq("wrap_sel3", 32'(q), 32'h03);
        restore_req = 1'b0; step(); step();

        // Selector beyond the valid count
        reset = 1'b0; step(); reset = 1'b1;
        capture(8'h0A); capture(8'h0B);
        d = 8'hC1; restore_req = 1'b1; restore_sel = 2'd2; step();
        check_eq("inv_err", 32'(restore_err), 1);
        check_eq("inv_q", 32'(q), 32'hC1);
        check_eq("inv_busy", 32'(busy), 0);
        restore_req = 1'b0; d = 8'hC2; step();
        check_eq("inv_err_clr", 32'(restore_err), 0);
        check_eq("inv_q2", 32'(q), 32'hC2);
        check_eq("inv_count", 32'(ckpt_count), 2);

        // Freeze outranks restore and capture
        freeze = 1'b1; restore_req = 1'b1; restore_sel = 2'd0; capture_en = 1'b1; d = 8'hD1;
        step();
        check_eq("frz_q", 32'(q), 32'hD1);
        check_eq("frz_count", 32'(ckpt_count), 2);
        check_eq("frz_err", 32'(restore_err), 0);
        check_eq("frz_busy", 32'(busy), 0);
        d = 8'hD2; step();
        check_eq("frz_q2", 32'(q), 32'hD2);
        check_eq("frz_count2", 32'(ckpt_count), 2);
        check_eq("frz_err2", 32'(restore_err), 0);
        freeze = 1'b0; capture_en = 1'b0; d = 8'hD3;
        step(); step();
        check_eq("unfrz_busy", 32'(busy), 1);
        check_eq("unfrz_q", 32'(q), 32'h0B);
        restore_req = 1'b0; step(); step();
        check_eq("unfrz_run", 32'(busy), 0);

        // Reset while a restore is in progress
        reset = 1'b0; step(); reset = 1'b1;
        capture(8'h11); capture(8'h22); capture(8'h33);
        d = 8'h44; step();
        restore_req = 1'b1; restore_sel = 2'd1; step();
        check_eq("mid_q", 32'(q), 32'h22);
        reset = 1'b0; step();
        check_eq("mid_rst_q", 32'(q), 32'h00);
        check_eq("mid_rst_count", 32'(ckpt_count), 0);
        check_eq("mid_rst_busy", 32'(busy), 0);
        check_eq("mid_rst_done", 32'(restore_done), 0);
        reset = 1'b1; restore_req = 1'b0; d = 8'h5A; step();
        check_eq("mid_after_done", 32'(restore_done), 0);
        check_eq("mid_after_busy", 32'(busy), 0);
        check_eq("mid_after_q", 32'(q), 32'h5A);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
